// File: rtl/pcie_tx_arb.sv
// pcie_tx_arb: round-robin arbiter sharing the PCIe VC0 tx port between a completion source and a credit-gated posted source
module pcie_tx_arb (
    input  logic        clk_125,
    input  logic        sys_rst,
    output logic        tx_req,
    input  logic        tx_rdy,
    output logic        tx_st,
    output logic        tx_end,
    output logic [15:0] tx_data,
    input  logic [8:0]  tx_ca_ph,
    input  logic [12:0] tx_ca_pd,
    input  logic        tx_ca_p_recheck,
    input  logic        req0,
    output logic        gnt0,
    input  logic        st0,
    input  logic        end0,
    input  logic [15:0] data0,
    input  logic        req1,
    input  logic [9:0]  len1,
    output logic        gnt1,
    input  logic        st1,
    input  logic        end1,
    input  logic [15:0] data1,
    output logic        busy,
    output logic [15:0] credit_stall_cnt
);
    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;
    state_t state, state_n;
    logic sel, sel_n, last, last_n, e0, e1, ph_ok, pd_ok;
    logic [10:0] need;
    assign need = ({len1 == 10'd0, len1} + 11'd3) >> 2;
    assign ph_ok = tx_ca_ph[8] | (tx_ca_ph[7:0] != 8'd0);
    assign pd_ok = tx_ca_pd[12] | (tx_ca_pd[11:0] >= {1'b0, need});
    assign e0 = req0;
    assign e1 = req1 & ~tx_ca_p_recheck & ph_ok & pd_ok;
    always_ff @(posedge clk_125) begin
        if (sys_rst) begin
            state <= IDLE;
            sel <= 1'b0;
            last <= 1'b1;
            credit_stall_cnt <= 16'd0;
        end else begin
            state <= state_n;
            sel <= sel_n;
            last <= last_n;
            if (state == IDLE && req1 && !e1 && credit_stall_cnt != 16'hFFFF)
                credit_stall_cnt <= credit_stall_cnt + 16'd1;
        end
    end
    always_comb begin
        state_n = state;
        sel_n = sel;
        last_n = last;
        case (state)
            IDLE: if (e0 | e1) begin
                state_n = REQ;
                sel_n = (e0 & e1) ? ~last : e1;
            end
            REQ: if (tx_rdy) begin
                state_n = XFER;
                last_n = sel;
            end
            XFER: if (sel ? end1 : end0) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    assign tx_req = state == REQ;
    assign gnt0 = state == XFER && !sel;
    assign gnt1 = state == XFER && sel;
    assign busy = state != IDLE;
    assign tx_st = (gnt0 & st0) | (gnt1 & st1);
    assign tx_end = (gnt0 & end0) | (gnt1 & end1);
    assign tx_data = gnt0 ? data0 : gnt1 ? data1 : 16'd0;
endmodule

// File: tb/tb_pcie_tx_arb.sv
// tb_pcie_tx_arb: directed bench with word and grant-order scoreboards for pcie_tx_arb
module tb_pcie_tx_arb;
    logic clk_125 = 1'b0, sys_rst = 1'b1;
    logic tx_req, tx_rdy = 1'b0, tx_st, tx_end;
    logic [15:0] tx_data;
    logic [8:0] tx_ca_ph = '0;
    logic [12:0] tx_ca_pd = '0;
    logic tx_ca_p_recheck = 1'b0;
    logic req0 = 1'b0, gnt0, st0 = 1'b0, end0 = 1'b0;
    logic [15:0] data0 = '0;
    logic req1 = 1'b0, gnt1, st1 = 1'b0, end1 = 1'b0;
    logic [9:0] len1 = '0;
    logic [15:0] data1 = '0;
    logic busy;
    logic [15:0] credit_stall_cnt;

    int n_assert = 0, n_fail = 0;
    int cyc = 0, end_cyc = 0, rdy_cnt = 0, rdy_delay = 0;
    int pos0 = 0, pos1 = 0, words0 = 4, words1 = 3, n_gnt = 0;
    bit hold0 = 0, hold1 = 0, gap_on = 0;
    logic g0_q = 1'b0, g1_q = 1'b0, req_q = 1'b0;
    logic [15:0] seq = 16'h0;
    logic [18:0] sb[$];
    logic exp_gnt[$];

    pcie_tx_arb dut (
        .clk_125(clk_125), .sys_rst(sys_rst), .tx_req(tx_req), .tx_rdy(tx_rdy),
        .tx_st(tx_st), .tx_end(tx_end), .tx_data(tx_data), .tx_ca_ph(tx_ca_ph),
        .tx_ca_pd(tx_ca_pd), .tx_ca_p_recheck(tx_ca_p_recheck), .req0(req0), .gnt0(gnt0),
        .st0(st0), .end0(end0), .data0(data0), .req1(req1), .len1(len1), .gnt1(gnt1),
        .st1(st1), .end1(end1), .data1(data1), .busy(busy), .credit_stall_cnt(credit_stall_cnt)
    );

    always #4 clk_125 = ~clk_125;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [18:0] w;
        logic g;
        @(posedge clk_125);
        #1;
        cyc++;
        if (tx_req) begin
            rdy_cnt++;
            tx_rdy = rdy_cnt > rdy_delay;
        end else begin
            rdy_cnt = 0;
            tx_rdy = 1'b0;
        end
        if (gnt0) begin
            st0 = pos0 == 0; end0 = pos0 == words0 - 1; data0 = 16'hA000 + seq; seq++;
            sb.push_back({1'b0, st0, end0, data0});
            pos0 = end0 ? 0 : pos0 + 1;
            if (!hold0) req0 = 1'b0;
        end else begin
            st0 = 1'b1; end0 = 1'b1; data0 = 16'hDEAD;
        end
        if (gnt1) begin
            st1 = pos1 == 0; end1 = pos1 == words1 - 1; data1 = 16'hB000 + seq; seq++;
            sb.push_back({1'b1, st1, end1, data1});
            pos1 = end1 ? 0 : pos1 + 1;
            if (!hold1) req1 = 1'b0;
        end else begin
            st1 = 1'b1; end1 = 1'b1; data1 = 16'hBEEF;
        end
        #1;
        if (gnt0 | gnt1) begin
            w = sb.pop_front();
            chk("tx_word", {13'd0, gnt1, tx_st, tx_end, tx_data}, {13'd0, w});
        end else
            chk("idle_out", {14'd0, tx_st, tx_end, tx_data}, 32'd0);
        chk("gnt_excl", gnt0 & gnt1, 0);
        chk("req_vs_gnt", tx_req & (gnt0 | gnt1), 0);
        if ((gnt0 && !g0_q) || (gnt1 && !g1_q)) begin
            chk("gnt_pending", exp_gnt.size() > 0, 1);
            if (exp_gnt.size() > 0) begin
                g = exp_gnt.pop_front();
                chk("gnt_order", gnt1, g);
            end
            n_gnt++;
        end
        if (tx_req && !req_q && gap_on) chk("req_gap", cyc - end_cyc, 2);
        if ((gnt0 | gnt1) && tx_end) end_cyc = cyc;
        g0_q = gnt0; g1_q = gnt1; req_q = tx_req;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((busy || req0 || req1) && n < 200) begin
            cycle();
            n++;
        end
        chk("done_timeout", n < 200, 1);
    endtask

    initial begin
        repeat (2) cycle();
        chk("rst_tx_req", tx_req, 0);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", credit_stall_cnt, 0);

        // single 4-word completion, tx_rdy two cycles after tx_req
        sys_rst = 1'b0; words0 = 4; rdy_delay = 2; req0 = 1'b1; exp_gnt.push_back(1'b0);
        cycle();
        chk("t1_req_n1", {busy, tx_req, gnt0}, 3'b110);
        cycle();
        chk("t1_req_n2", {tx_req, gnt0}, 2'b10);
        cycle();
        chk("t1_req_m", {tx_req, tx_rdy, gnt0}, 3'b110);
        cycle();
        chk("t1_m1", {tx_req, gnt0, tx_st, tx_end}, 4'b0110);
        repeat (2) cycle();
        chk("t1_m3", {gnt0, tx_end}, 2'b10);
        cycle();
        chk("t1_m4", {gnt0, tx_end}, 2'b11);
        cycle();
        chk("t1_m5", {gnt0, busy}, 2'b00);

        // both held continuously with infinite credits
        sys_rst = 1'b1;
        repeat (2) cycle();
        sys_rst = 1'b0; rdy_delay = 0; words0 = 3; words1 = 2; len1 = 10'd4;
        tx_ca_ph = 9'h100; tx_ca_pd = 13'h1000; hold0 = 1; hold1 = 1; req0 = 1'b1; req1 = 1'b1;
        exp_gnt.push_back(1'b0); exp_gnt.push_back(1'b1); exp_gnt.push_back(1'b0); exp_gnt.push_back(1'b1);
        for (int i = 0; i < 100 && n_gnt < 2; i++) cycle();
        gap_on = 1;
        for (int i = 0; i < 100 && n_gnt < 5; i++) cycle();
        gap_on = 0; hold0 = 0; hold1 = 0; req0 = 1'b0; req1 = 1'b0;
        wait_done();
        chk("t2_grants", n_gnt, 5);

        // posted data credit stall then release
        chk("t3_cnt0", credit_stall_cnt, 0);
        tx_ca_ph = 9'd5; tx_ca_pd = 13'd1; len1 = 10'd8; words1 = 3; rdy_delay = 1; req1 = 1'b1;
        exp_gnt.push_back(1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("t3_stall_req", tx_req, 0);
        end
        chk("t3_cnt10", credit_stall_cnt, 10);
        tx_ca_pd = 13'd2;
        cycle();
        chk("t3_req", tx_req, 1);
        chk("t3_cnt_hold", credit_stall_cnt, 10);
        wait_done();

        // len1=0 needs 256 data credits
        len1 = 10'd0; tx_ca_pd = 13'd255; req1 = 1'b1;
        repeat (3) cycle();
        chk("t4_pd255", tx_req, 0);
        chk("t4_cnt", credit_stall_cnt, 13);
        tx_ca_pd = 13'd256; exp_gnt.push_back(1'b1);
        cycle();
        chk("t4_pd256", tx_req, 1);
        wait_done();
        tx_ca_pd = 13'h1000; req1 = 1'b1; exp_gnt.push_back(1'b1);
        cycle();
        chk("t4_pd_inf", tx_req, 1);
        wait_done();
        tx_ca_ph = 9'h100; tx_ca_pd = 13'd256; req1 = 1'b1; exp_gnt.push_back(1'b1);
        cycle();
        chk("t4_ph_inf", tx_req, 1);
        wait_done();
        tx_ca_ph = 9'h000; tx_ca_pd = 13'h1000; req1 = 1'b1;
        repeat (2) cycle();
        chk("t4_ph0", tx_req, 0);
        chk("t4_cnt_ph0", credit_stall_cnt, 15);
        req1 = 1'b0;
        cycle();

        // recheck blocks a posted start for one cycle
        tx_ca_ph = 9'd5; tx_ca_pd = 13'd100; len1 = 10'd8; req1 = 1'b1; tx_ca_p_recheck = 1'b1;
        exp_gnt.push_back(1'b1);
        cycle();
        chk("t5_recheck_req", tx_req, 0);
        chk("t5_recheck_cnt", credit_stall_cnt, 16);
        tx_ca_p_recheck = 1'b0;
        cycle();
        chk("t5_after_req", tx_req, 1);
        wait_done();
        words0 = 2; req0 = 1'b1; exp_gnt.push_back(1'b0);
        wait_done();
        req0 = 1'b1; req1 = 1'b1; tx_ca_p_recheck = 1'b1;
        exp_gnt.push_back(1'b0); exp_gnt.push_back(1'b1);
        cycle();
        chk("t5_req0_wins", tx_req, 1);
        chk("t5_cnt17", credit_stall_cnt, 17);
        tx_ca_p_recheck = 1'b0;
        wait_done();
        chk("t5_cnt_end", credit_stall_cnt, 17);

        // reset one cycle into XFER
        tx_ca_ph = 9'h100; tx_ca_pd = 13'h1000; words1 = 4; req1 = 1'b1; exp_gnt.push_back(1'b1);
        for (int i = 0; i < 20 && !gnt1; i++) cycle();
        chk("t6_gnt1", gnt1, 1);
        sys_rst = 1'b1;
        cycle();
        chk("t6_rst", {gnt1, tx_req, busy}, 3'b000);
        chk("t6_rst_cnt", credit_stall_cnt, 0);
        sys_rst = 1'b0; pos1 = 0; words0 = 2; words1 = 2; req0 = 1'b1; req1 = 1'b1;
        exp_gnt.push_back(1'b0); exp_gnt.push_back(1'b1);
        cycle();
        chk("t6_req", tx_req, 1);
        wait_done();
        chk("exp_gnt_empty", exp_gnt.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/pcie_tx_arb.md
# pcie_tx_arb

Transmit-side arbiter that shares the single PCIe core VC0 transmit port (tx_req/tx_rdy/tx_st/tx_end/tx_data) between two TLP sources in the ethpipe datapath. Requester 0 is the completion source for host register/BAR reads. Requester 1 is the posted memory-write (DMA) source. The block sits between those sources and the PCIe core in the clk_125 domain. It performs round-robin arbitration, gates posted TLPs on the core's advertised posted header/data credits, muxes the granted source's stream onto the core, and counts credit stalls.

## Interface
- No parameters; data width fixed at 16 bits and the requester count fixed at 2.
- clk_125  in  1  system clock, 125 MHz; all logic on its rising edge
- sys_rst  in  1  reset, synchronous, active-high
- tx_req  out  1  request to the core
- tx_rdy  in  1  core grant of the transmit port
- tx_st  out  1  start-of-TLP, muxed from the granted requester
- tx_end  out  1  end-of-TLP, muxed from the granted requester
- tx_data  out  16  TLP data, muxed from the granted requester
- tx_ca_ph  in  9  posted header credits available; bit 8 = infinite
- tx_ca_pd  in  13  posted data credits available (16-byte units); bit 12 = infinite
- tx_ca_p_recheck  in  1  core is revising posted credits; do not start a posted grant this cycle
- req0  in  1  completion source requests (level, held until gnt0)
- gnt0  out  1  requester 0 owns the port
- st0 / end0  in  1 each  requester 0 start / end
- data0  in  16  requester 0 data
- req1  in  1  posted source requests (level, held until gnt1)
- len1  in  10  requester 1 TLP payload length in DW; 0 encodes 1024; stable while req1 high
- gnt1  out  1  requester 1 owns the port
- st1 / end1  in  1 each  requester 1 start / end
- data1  in  16  requester 1 data
- busy  out  1  state is not IDLE
- credit_stall_cnt  out  16  saturating count of posted credit-stall cycles

## Operation
- States: IDLE, REQ, XFER.
- IDLE:
  - Eligibility: e0 = req0. e1 = req1 & ~tx_ca_p_recheck & ph_ok & pd_ok.
  - ph_ok = tx_ca_ph[8] | (tx_ca_ph[7:0] != 0).
  - pd_ok = tx_ca_pd[12] | (tx_ca_pd[11:0] >= need).
  - need = ({len1==0, len1} + 3) >> 2, computed 11 bits wide; len1=0 gives 256.
  - Round-robin pointer `last` is 1 bit and resets to 1, so requester 0 wins the first tie.
  - If both are eligible, select the one not equal to last. Otherwise select the single eligible one.
  - On a selection: latch sel, set tx_req=1, go to REQ.
- REQ:
  - Hold tx_req=1 until tx_rdy is sampled high.
  - On that edge: tx_req<=0, gnt[sel]<=1, last<=sel, go to XFER.
  - Eligibility is not re-evaluated in REQ; the latched selection is committed.
- XFER:
  - tx_st, tx_end and tx_data are combinational muxes of the granted requester's st/end/data.
  - With no grant they drive 0.
  - The granted requester drives st with its first word in the first cycle its gnt is high.
  - On the edge where the granted end is sampled high: gnt<=0, go to IDLE.
  - A single-word TLP (st and end high in the same cycle) is legal.
- credit_stall_cnt increments in any IDLE cycle with req1=1 and e1=0. It saturates at 16'hFFFF.
- Reset values: tx_req=0, gnt0=0, gnt1=0, busy=0, credit_stall_cnt=0, last=1, state=IDLE. tx_st, tx_end and tx_data read 0 because no grant is active.
- sys_rst asserted mid-REQ or mid-XFER: immediate return to the reset values on the next edge. The PCIe core is reset by the same system reset, so no TLP is completed or aborted.

## Timing
- Cycle numbering below: the request is sampled in IDLE at cycle N.
- Request to core: tx_req is high from cycle N+1.
- tx_rdy sampled at cycle M: gnt and st are high at M+1, and tx_req is low at M+1.
- End: the granted end is sampled at cycle E.
  - gnt is low at E+1, with state IDLE.
  - The next tx_req is high at E+2 at the earliest.
- Back-to-back TLPs therefore have at least one idle cycle between tx_end and the next tx_req.
- The credit check uses the tx_ca_* values in the IDLE decision cycle only.
- gnt0 and gnt1 are never high together. tx_req is never high while either grant is high.

## Test plan
- Reset, then req0=1 with a 4-word TLP, tx_rdy given 2 cycles after tx_req:
  - tx_req high N+1..M; gnt0 high M+1..M+4.
  - tx_st at M+1, tx_end at M+4; data0 passes through unchanged.
- req0 and req1 both held continuously, credits infinite: grant order is 0,1,0,1. Each grant is separated by the E+2 request gap.
- req1 with len1=8 (need 2), tx_ca_pd=1, tx_ca_ph=5, for 10 cycles:
  - No tx_req; credit_stall_cnt=10.
  - Raise tx_ca_pd to 2: tx_req on the next cycle, gnt1 after tx_rdy.
- len1=0 with tx_ca_pd=255 stalls. tx_ca_pd=256 proceeds. tx_ca_pd=13'h1000 (infinite) proceeds. tx_ca_ph=9'h100 with pd_ok proceeds.
- tx_ca_p_recheck pulsed high in the IDLE cycle with req1=1 and credits ok:
  - No selection that cycle; stall count +1.
  - Selection on the following cycle.
  - A concurrent req0 is granted instead if it is eligible.
- sys_rst asserted one cycle into XFER: next edge gnt1=0, tx_req=0, busy=0, credit_stall_cnt=0. After release, the first tie goes to requester 0.
